muldiv_unit: RTL and testbench

- Multi-cycle RV32M multiply/divide responder; an iterative alternative to the single-cycle M-extension ALU path.
- Accepts one operation per request over a valid/ready handshake from the execute stage.
- Computes with a radix-2 shift-add multiplier or a restoring divider over DATA_WIDTH iterations.
- Returns the 32-bit result over a second valid/ready handshake; the core stalls on busy.

---
 rtl/muldiv_unit_if.sv | 25 ++
 rtl/muldiv_unit.sv | 194 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/response handshake bundle for muldiv_unit
interface muldiv_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic [OP_WIDTH-1:0]   req_op;
  logic [DATA_WIDTH-1:0] req_op1;
  logic [DATA_WIDTH-1:0] req_op2;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  busy;

  modport master (
    output req_valid, req_op, req_op1, req_op2, resp_ready,
    input  req_ready, resp_valid, resp_data, busy
  );

  modport slave (
    input  req_valid, req_op, req_op1, req_op2, resp_ready,
    output req_ready, resp_valid, resp_data, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 5
) (
  input logic         clk,
  input logic         rst,
  muldiv_unit_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 2) ? $clog2(W) : 1;

  localparam logic [OP_WIDTH-1:0] OP_MUL    = OP_WIDTH'(10);
  localparam logic [OP_WIDTH-1:0] OP_MULH   = OP_WIDTH'(11);
  localparam logic [OP_WIDTH-1:0] OP_MULHSU = OP_WIDTH'(12);
  localparam logic [OP_WIDTH-1:0] OP_MULHU  = OP_WIDTH'(13);
  localparam logic [OP_WIDTH-1:0] OP_DIV    = OP_WIDTH'(14);
  localparam logic [OP_WIDTH-1:0] OP_DIVU   = OP_WIDTH'(15);
  localparam logic [OP_WIDTH-1:0] OP_REM    = OP_WIDTH'(16);
  localparam logic [OP_WIDTH-1:0] OP_REMU   = OP_WIDTH'(17);

  localparam logic [W-1:0] MIN_NEG  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
  localparam logic [CW-1:0] LAST_IT = CW'(W - 1);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [W-1:0]          a_q, a_d;
  logic [W-1:0]          b_q, b_d;
  logic [W-1:0]          dv_q, dv_d;
  logic [W:0]            hi_q, hi_d;
  logic [W-1:0]          lo_q, lo_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  neg_q, neg_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [W-1:0]          resp_data_q, resp_data_d;
  logic                  busy_q, busy_d;

  logic                  is_mul, is_div, is_rem, sgn_a, sgn_b;
  logic                  a_neg, b_neg;
  logic [W-1:0]          mag_a, mag_b;
  logic [W:0]            mul_sum, div_shift, div_diff;
  logic [2*W-1:0]        prod, prod_s;
  logic [W-1:0]          quot_s, rem_s;

  assign bus.req_ready  = (state_q == S_IDLE) && !rst;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.busy       = busy_q;

  always_comb begin
    is_mul = (op_q >= OP_MUL) && (op_q <= OP_MULHU);
    is_div = (op_q >= OP_DIV) && (op_q <= OP_REMU);
    is_rem = (op_q == OP_REM) || (op_q == OP_REMU);
    sgn_a  = (op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_DIV) || (op_q == OP_REM);
    sgn_b  = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
    a_neg  = sgn_a && a_q[W-1];
    b_neg  = sgn_b && b_q[W-1];
    // Negating MIN_NEG yields MIN_NEG, which read unsigned is exactly 2^(W-1).
    mag_a  = a_neg ? (~a_q + 1'b1) : a_q;
    mag_b  = b_neg ? (~b_q + 1'b1) : b_q;

    mul_sum   = hi_q + (lo_q[0] ? {1'b0, dv_q} : {(W+1){1'b0}});
    div_shift = {hi_q[W-1:0], lo_q[W-1]};
    div_diff  = div_shift - {1'b0, dv_q};

    prod   = {hi_q[W-1:0], lo_q};
    prod_s = neg_q ? (~prod + 1'b1) : prod;
    quot_s = neg_q ? (~lo_q + 1'b1) : lo_q;
    rem_s  = neg_q ? (~hi_q[W-1:0] + 1'b1) : hi_q[W-1:0];
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    dv_d         = dv_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    cnt_d        = cnt_q;
    neg_d        = neg_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          op_d    = bus.req_op;
          a_d     = bus.req_op1;
          b_d     = bus.req_op2;
          state_d = S_PREP;
        end
      end

      S_PREP: begin
        cnt_d = '0;
        hi_d  = '0;
        if (is_mul) begin
          neg_d   = (op_q != OP_MUL) && (a_neg ^ b_neg);
          dv_d    = mag_a;
          lo_d    = mag_b;
          state_d = S_CALC;
        end else if (is_div && (b_q == '0)) begin
          resp_data_d  = is_rem ? a_q : ALL_ONES;
          resp_valid_d = 1'b1;
          state_d      = S_DONE;
        end else if (is_div && sgn_a && (a_q == MIN_NEG) && (b_q == ALL_ONES)) begin
          resp_data_d  = is_rem ? '0 : MIN_NEG;
          resp_valid_d = 1'b1;
          state_d      = S_DONE;
        end else if (is_div) begin
          // Remainder takes the dividend's sign; quotient the XOR of both.
          neg_d   = is_rem ? a_neg : (a_neg ^ b_neg);
          dv_d    = mag_b;
          lo_d    = mag_a;
          state_d = S_CALC;
        end else begin
          resp_data_d  = '0;
          resp_valid_d = 1'b1;
          state_d      = S_DONE;
        end
      end

      S_CALC: begin
        if (is_mul) begin
          hi_d = {1'b0, mul_sum[W:1]};
          lo_d = {mul_sum[0], lo_q[W-1:1]};
        end else if (div_diff[W]) begin
          hi_d = div_shift;
          lo_d = {lo_q[W-2:0], 1'b0};
        end else begin
          hi_d = div_diff;
          lo_d = {lo_q[W-2:0], 1'b1};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IT) state_d = S_FIX;
      end

      S_FIX: begin
        if (op_q == OP_MUL)  resp_data_d = prod_s[W-1:0];
        else if (is_mul)     resp_data_d = prod_s[2*W-1:W];
        else if (is_rem)     resp_data_d = rem_s;
        else                 resp_data_d = quot_s;
        resp_valid_d = 1'b1;
        state_d      = S_DONE;
      end

      S_DONE: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      dv_q         <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      cnt_q        <= '0;
      neg_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      dv_q         <= dv_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      cnt_q        <= cnt_d;
      neg_q        <= neg_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      busy_q       <= busy_d;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
  localparam logic [4:0] OP_MUL    = 5'b01010;
  localparam logic [4:0] OP_MULH   = 5'b01011;
  localparam logic [4:0] OP_MULHSU = 5'b01100;
  localparam logic [4:0] OP_MULHU  = 5'b01101;
  localparam logic [4:0] OP_DIV    = 5'b01110;
  localparam logic [4:0] OP_DIVU   = 5'b01111;
  localparam logic [4:0] OP_REM    = 5'b10000;
  localparam logic [4:0] OP_REMU   = 5'b10001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  muldiv_unit_if #(.DATA_WIDTH(32), .OP_WIDTH(5)) bus ();

  muldiv_unit #(.DATA_WIDTH(32), .OP_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_op1   = a;
    bus.req_op2   = b;
    @(posedge clk);
  endtask

  // cyc counts rising edges from the accept edge to the edge that first samples resp_valid high.
  task automatic wait_resp(output int cyc, output bit busy_ok);
    cyc = 1;
    busy_ok = 1'b1;
    while (1) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.resp_valid === 1'b1) break;
      cyc++;
      if (cyc > 100) break;
    end
  endtask

  task automatic take(input string tag);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(bus.resp_valid), 32'd0);
  endtask

  task automatic run(input string tag, input logic [4:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int lat);
    int cyc;
    bit bok;
    send(op, a, b);
    wait_resp(cyc, bok);
    chk({tag, "_latency"}, 32'(cyc), 32'(lat));
    chk({tag, "_data"}, bus.resp_data, exp);
    chk({tag, "_busy"}, 32'(bok), 32'd1);
    take(tag);
  endtask

  initial begin
    int  cyc;
    bit  bok, stable, rdy_low, seen;

    bus.req_valid  = 1'b0;
    bus.req_op     = '0;
    bus.req_op1    = '0;
    bus.req_op2    = '0;
    bus.resp_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_req_ready", 32'(bus.req_ready), 32'd1);

    run("mul_7x6",      OP_MUL,    32'd7,        32'd6,        32'd42,       35);
    run("mulh_m1xm1",   OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 35);
    run("mulhu_max",    OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 35);
    run("mulhsu_max",   OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 35);
    run("mulh_min",     OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 35);
    run("div_m7_2",     OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 35);
    run("rem_m7_2",     OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 35);
    run("divu_100_7",   OP_DIVU,   32'd100,      32'd7,        32'd14,       35);
    run("remu_100_7",   OP_REMU,   32'd100,      32'd7,        32'd2,        35);
    run("divu_by0",     OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 2);
    run("rem_by0",      OP_REM,    32'd5,        32'd0,        32'd5,        2);
    run("div_ovf",      OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
    run("rem_ovf",      OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2);
    run("bad_op",       5'b00011,  32'd123,      32'd456,      32'h00000000, 2);

    // Backpressure: result held in DONE while a second request waits.
    send(OP_MUL, 32'd3, 32'd5);
    wait_resp(cyc, bok);
    chk("bp_latency", 32'(cyc), 32'd35);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_REMU;
    bus.req_op1   = 32'd100;
    bus.req_op2   = 32'd7;
    stable  = 1'b1;
    rdy_low = 1'b1;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'd15) stable = 1'b0;
      if (bus.req_ready !== 1'b0) rdy_low = 1'b0;
    end
    chk("bp_stable", 32'(stable), 32'd1);
    chk("bp_req_ready_low", 32'(rdy_low), 32'd1);
    chk("bp_data", bus.resp_data, 32'd15);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk("bp_hs_valid", 32'(bus.resp_valid), 32'd0);
    chk("bp_hs_busy", 32'(bus.busy), 32'd0);
    chk("bp_hs_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    wait_resp(cyc, bok);
    chk("bp_next_latency", 32'(cyc), 32'd35);
    chk("bp_next_data", bus.resp_data, 32'd2);
    take("bp_next");

    // Reset during CALC iteration 15 aborts without a response.
    send(OP_DIVU, 32'd1000, 32'd10);
    repeat (16) @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_valid", 32'(bus.resp_valid), 32'd0);
    chk("abort_req_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b0) seen = 1'b1;
    end
    chk("abort_no_resp", 32'(seen), 32'd0);
    run("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 35);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
